// File: rtl/user_pkg.sv
// Shared definitions for the user domain.
// The manager list is used by the crossbar to index user-domain managers.
package user_pkg;

    localparam int unsigned NumUserDomainManagers = 1;

    typedef enum int unsigned {
        UserCopyMgr = 0
    } user_mgr_e;

endpackage

// File: rtl/user_obi_copy_mgr.sv
// OBI copy manager for the user domain.
// Copies a block of 32-bit words from a source to a destination address,
// issuing one read followed by one write per word, with at most one
// transaction outstanding on the bus at any time.
module user_obi_copy_mgr #(
    parameter int unsigned LenWidth  = 16,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [AddrWidth-1:0]   src_addr_i,
    input  logic [AddrWidth-1:0]   dst_addr_i,
    input  logic [LenWidth-1:0]    len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [LenWidth-1:0]    count_o,
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic                   obi_we_o,
    output logic [DataWidth/8-1:0] obi_be_o,
    output logic [DataWidth-1:0]   obi_wdata_o,
    input  logic                   obi_rvalid_i,
    input  logic [DataWidth-1:0]   obi_rdata_i,
    input  logic                   obi_err_i
);

    import user_pkg::*;

    typedef logic [2:0] copy_state_e;

    localparam copy_state_e StIdle  = 3'd0;
    localparam copy_state_e StRdReq = 3'd1;
    localparam copy_state_e StRdRsp = 3'd2;
    localparam copy_state_e StWrReq = 3'd3;
    localparam copy_state_e StWrRsp = 3'd4;
    localparam copy_state_e StDone  = 3'd5;

    copy_state_e          state;
    logic [AddrWidth-1:0] src_base;
    logic [AddrWidth-1:0] dst_base;
    logic [LenWidth-1:0]  len;
    logic [LenWidth-1:0]  count;
    logic [LenWidth-1:0]  count_next;
    logic [DataWidth-1:0] buffer;
    logic                 abort_pend;
    logic                 err;
    logic                 job_active;
    logic [AddrWidth-1:0] word_offset;

    assign count_next  = count + 1'b1;
    assign word_offset = AddrWidth'({count, 2'b00});
    assign job_active  = (state == StRdReq) || (state == StRdRsp) ||
                         (state == StWrReq) || (state == StWrRsp);

    // Main copy FSM: sequences read/write pairs, tracks words written and
    // records abort requests and bus errors.  Requests are held until granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= StIdle;
            src_base   <= '0;
            dst_base   <= '0;
            len        <= '0;
            count      <= '0;
            buffer     <= '0;
            abort_pend <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (job_active && abort_i) begin
                abort_pend <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (start_i) begin
                        src_base   <= {src_addr_i[AddrWidth-1:2], 2'b00};
                        dst_base   <= {dst_addr_i[AddrWidth-1:2], 2'b00};
                        len        <= len_i;
                        count      <= '0;
                        err        <= 1'b0;
                        abort_pend <= 1'b0;
                        state      <= (len_i != '0) ? StRdReq : StDone;
                    end
                end
                StRdReq: begin
                    if (obi_gnt_i) begin
                        state <= StRdRsp;
                    end
                end
                StRdRsp: begin
                    if (obi_rvalid_i) begin
                        if (obi_err_i) begin
                            err   <= 1'b1;
                            state <= StDone;
                        end else begin
                            buffer <= obi_rdata_i;
                            state  <= StWrReq;
                        end
                    end
                end
                StWrReq: begin
                    if (obi_gnt_i) begin
                        state <= StWrRsp;
                    end
                end
                StWrRsp: begin
                    if (obi_rvalid_i) begin
                        if (obi_err_i) begin
                            err   <= 1'b1;
                            state <= StDone;
                        end else begin
                            count <= count_next;
                            if ((count_next == len) || abort_pend || abort_i) begin
                                state <= StDone;
                            end else begin
                                state <= StRdReq;
                            end
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Bus and status outputs decoded from the current state; address and
    // write data are zero whenever no request is being presented.
    always_comb begin
        busy_o      = job_active;
        done_o      = (state == StDone);
        err_o       = err;
        count_o     = count;
        obi_req_o   = 1'b0;
        obi_we_o    = 1'b0;
        obi_addr_o  = '0;
        obi_wdata_o = '0;
        obi_be_o    = '1;
        if (state == StRdReq) begin
            obi_req_o  = 1'b1;
            obi_addr_o = src_base + word_offset;
        end else if (state == StWrReq) begin
            obi_req_o   = 1'b1;
            obi_we_o    = 1'b1;
            obi_addr_o  = dst_base + word_offset;
            obi_wdata_o = buffer;
        end
    end

endmodule

// File: tb/tb_user_obi_copy_mgr.sv
// Self-checking bench for user_obi_copy_mgr: a small OBI memory model serves
// reads with an address-derived pattern and logs every write.
module tb_user_obi_copy_mgr;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] count;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic        obi_err;

    int num_compared   = 0;
    int num_mismatched = 0;

    int stall_req  = 0;
    int err_rd_idx = -1;
    int wait_cnt   = 0;
    int grants     = 0;
    int rd_count   = 0;

    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          stall;
        int          err_idx;
        bit          abort;
        bit          busy_start;
        int          exp_count;
        bit          exp_err;
        int          exp_done_cycle;
        int          exp_reads;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    user_obi_copy_mgr dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .abort_i      (abort),
        .src_addr_i   (src_addr),
        .dst_addr_i   (dst_addr),
        .len_i        (len),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .count_o      (count),
        .obi_req_o    (obi_req),
        .obi_gnt_i    (obi_gnt),
        .obi_addr_o   (obi_addr),
        .obi_we_o     (obi_we),
        .obi_be_o     (obi_be),
        .obi_wdata_o  (obi_wdata),
        .obi_rvalid_i (obi_rvalid),
        .obi_rdata_i  (obi_rdata),
        .obi_err_i    (obi_err)
    );

    function automatic logic [31:0] src_pattern(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Grant withheld for stall_req cycles on the first request of a job only.
    assign obi_gnt = obi_req && ((grants != 0) || (wait_cnt >= stall_req));

    // Memory model: one-cycle response after each grant, logs all traffic.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            obi_rvalid <= 1'b0;
            obi_rdata  <= '0;
            obi_err    <= 1'b0;
            wait_cnt   <= 0;
            grants     <= 0;
            rd_count   <= 0;
        end else begin
            obi_rvalid <= 1'b0;
            obi_rdata  <= '0;
            obi_err    <= 1'b0;
            if (obi_req && !obi_gnt) begin
                wait_cnt <= wait_cnt + 1;
            end
            if (obi_req && obi_gnt) begin
                grants     <= grants + 1;
                obi_rvalid <= 1'b1;
                if (obi_we) begin
                    wr_addr_q.push_back(obi_addr);
                    wr_data_q.push_back(obi_wdata);
                end else begin
                    obi_rdata <= src_pattern(obi_addr);
                    obi_err   <= (rd_count == err_rd_idx);
                    rd_count  <= rd_count + 1;
                    rd_addr_q.push_back(obi_addr);
                end
            end
            if (!busy) begin
                wait_cnt <= 0;
                grants   <= 0;
                rd_count <= 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_compared++;
        if (act !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int          cycle;
        int          req_cycles;
        int          stall_seen;
        bit          abort_sent;
        logic [31:0] src_base;
        logic [31:0] dst_base;
        logic [31:0] exp_addr;
        @(negedge clk);
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        stall_req  = v.stall;
        err_rd_idx = v.err_idx;
        src_addr   = v.src;
        dst_addr   = v.dst;
        len        = v.len;
        start      = 1'b1;
        src_base   = {v.src[31:2], 2'b00};
        dst_base   = {v.dst[31:2], 2'b00};
        @(negedge clk);
        start      = 1'b0;
        cycle      = 1;
        req_cycles = 0;
        stall_seen = 0;
        abort_sent = 1'b0;
        checkOutput("err_cleared_on_start", {31'b0, err}, 32'd0);
        checkOutput("busy_after_start", {31'b0, busy}, {31'b0, (v.len != 16'd0)});
        while (!done && cycle < 200) begin
            if (obi_req) begin
                req_cycles++;
            end
            if (v.stall > 0 && obi_req && !obi_gnt) begin
                stall_seen++;
                checkOutput("stall_addr", obi_addr, src_base);
                checkOutput("stall_we", {31'b0, obi_we}, 32'd0);
            end
            if (v.abort && !abort_sent && obi_req && !obi_we) begin
                abort      = 1'b1;
                abort_sent = 1'b1;
            end
            if (v.busy_start && cycle == 3) begin
                start    = 1'b1;
                src_addr = 32'hDEAD_0000;
                len      = 16'd5;
            end
            @(negedge clk);
            cycle++;
            start = 1'b0;
            abort = 1'b0;
        end
        checkOutput("done_cycle", cycle, v.exp_done_cycle);
        checkOutput("busy_in_done", {31'b0, busy}, 32'd0);
        checkOutput("count_final", {16'b0, count}, v.exp_count);
        checkOutput("err_final", {31'b0, err}, {31'b0, v.exp_err});
        checkOutput("stall_cycles", stall_seen, v.stall);
        checkOutput("req_cycles", req_cycles, v.exp_reads + v.exp_count + v.stall);
        checkOutput("num_reads", rd_addr_q.size(), v.exp_reads);
        checkOutput("num_writes", wr_addr_q.size(), v.exp_count);
        for (int i = 0; i < rd_addr_q.size() && i < v.exp_reads; i++) begin
            exp_addr = src_base + 32'(4 * i);
            checkOutput("read_addr", rd_addr_q[i], exp_addr);
        end
        for (int i = 0; i < wr_addr_q.size() && i < v.exp_count; i++) begin
            exp_addr = dst_base + 32'(4 * i);
            checkOutput("write_addr", wr_addr_q[i], exp_addr);
            checkOutput("write_data", wr_data_q[i], src_pattern(src_base + 32'(4 * i)));
        end
        @(negedge clk);
        checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        int guard;
        // src, dst, len, stall, err_idx, abort, busy_start, exp_count, exp_err, exp_done_cycle, exp_reads
        vecs[0] = '{32'h1000_0000, 32'h2000_1000, 16'd3, 0, -1, 1'b0, 1'b0, 3, 1'b0, 13, 3};
        vecs[1] = '{32'h1000_0100, 32'h2000_1100, 16'd2, 5, -1, 1'b0, 1'b0, 2, 1'b0, 14, 2};
        vecs[2] = '{32'h1000_0000, 32'h2000_0000, 16'd0, 0, -1, 1'b0, 1'b0, 0, 1'b0, 1,  0};
        vecs[3] = '{32'h3000_0000, 32'h4000_0000, 16'd4, 0,  1, 1'b0, 1'b0, 1, 1'b1, 7,  2};
        vecs[4] = '{32'h3000_0040, 32'h4000_0040, 16'd1, 0, -1, 1'b0, 1'b0, 1, 1'b0, 5,  1};
        vecs[5] = '{32'h5000_0000, 32'h6000_0000, 16'd8, 0, -1, 1'b1, 1'b0, 1, 1'b0, 5,  1};
        vecs[6] = '{32'hFFFF_FFFC, 32'h7000_0000, 16'd2, 0, -1, 1'b0, 1'b0, 2, 1'b0, 9,  2};
        vecs[7] = '{32'h1100_0000, 32'h2200_0000, 16'd3, 0, -1, 1'b0, 1'b1, 3, 1'b0, 13, 3};
        vecs[8] = '{32'h1234_5673, 32'h2345_6782, 16'd2, 0, -1, 1'b0, 1'b0, 2, 1'b0, 9,  2};

        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_err", {31'b0, err}, 32'd0);
        checkOutput("reset_count", {16'b0, count}, 32'd0);
        checkOutput("reset_req", {31'b0, obi_req}, 32'd0);
        checkOutput("reset_addr", obi_addr, 32'd0);
        checkOutput("reset_we", {31'b0, obi_we}, 32'd0);
        checkOutput("reset_wdata", obi_wdata, 32'd0);
        checkOutput("be_constant", {28'b0, obi_be}, 32'h0000_000F);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            $display("[TB] vector %0d: src=0x%08h dst=0x%08h len=%0d", i, vecs[i].src, vecs[i].dst, vecs[i].len);
            applyStimulus(vecs[i]);
        end

        // Asynchronous reset while a write request is pending.
        @(negedge clk);
        src_addr   = 32'h0800_0000;
        dst_addr   = 32'h0900_0000;
        len        = 16'd4;
        stall_req  = 0;
        err_rd_idx = -1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(obi_req && obi_we) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reach_wr_req", {31'b0, (obi_req && obi_we)}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midjob_reset_req", {31'b0, obi_req}, 32'd0);
        checkOutput("midjob_reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("midjob_reset_count", {16'b0, count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_reset", {31'b0, busy}, 32'd0);
        applyStimulus(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
